fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic [$clog2(NUM_SRC)-1:0] winner,
  output logic                       any_req
);

  localparam int ID_W = $clog2(NUM_SRC);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NUM_SRC]) begin
        winner  = ID_W'((int'(ptr) + off) % NUM_SRC);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging NUM_SRC word streams into one FIFO write port.
// Optional per-requester accepted-word counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 24,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_last,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_full,
  output logic [$clog2(NUM_SRC)-1:0]    grant_id,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic [$clog2(NUM_SRC)-1:0]    stat_sel,
  output logic [15:0]                   stat_cnt,
`endif
  output logic                          busy
);

  localparam int ID_W = $clog2(NUM_SRC);

  state_t                 state, state_next;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        winner;
  logic                   any_req;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   xfer;
  logic                   burst_full;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic [BURST_CNT_W:0]   cnt_inc;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req     (src_valid),
    .ptr     (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == ID_W'(i)) fifo_wr_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_valid  = src_valid[grant_id];
  assign sel_last   = src_last[grant_id];
  assign xfer       = (state == GRANT) && sel_valid && !fifo_wr_full;
  // Widened so MAX_BURST=256 is reachable with an 8-bit counter.
  assign cnt_inc    = {1'b0, burst_cnt} + 1'b1;
  assign burst_full = (cnt_inc == (BURST_CNT_W+1)'(MAX_BURST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    src_ready  = '0;
    fifo_wr_en = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = GRANT;
      end
      GRANT: begin
        busy                = 1'b1;
        src_ready[grant_id] = !fifo_wr_full;
        fifo_wr_en          = xfer;
        if (!sel_valid || (xfer && (sel_last || burst_full))) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A full FIFO simply stalls here: no transfer, so the count and grant hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        grant_id  <= winner;
        burst_cnt <= '0;
      end
    end else begin
      if (xfer) burst_cnt <= burst_cnt + 1'b1;
      if (state_next == IDLE)
        rr_ptr <= (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stat_cnts [NUM_SRC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) stat_cnts[i] <= '0;
      stat_cnt <= '0;
    end else begin
      if (xfer && (stat_cnts[grant_id] != 16'hFFFF))
        stat_cnts[grant_id] <= stat_cnts[grant_id] + 16'd1;
      stat_cnt <= (int'(stat_sel) < NUM_SRC) ? stat_cnts[stat_sel] : 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: queued source words, expected write order and burst shapes.
module tb_fifo_wr_arbiter;

  localparam int NUM_SRC   = 4;
  localparam int DW        = 24;
  localparam int MAX_BURST = 8;
  localparam int ID_W      = 2;

  typedef struct { logic [DW-1:0] data; logic last; } word_t;
  typedef struct { int src; logic [DW-1:0] data; }   sb_t;
  typedef struct { int src; int len; int cyc; }      burst_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_SRC-1:0]     src_valid;
  logic [NUM_SRC-1:0]     src_last;
  logic [NUM_SRC*DW-1:0]  src_data;
  logic [NUM_SRC-1:0]     src_ready;
  logic                   fifo_wr_en;
  logic [DW-1:0]          fifo_wr_data;
  logic                   fifo_wr_full;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [ID_W-1:0]        stat_sel;
  logic [15:0]            stat_cnt;
`endif

  word_t  src_q [NUM_SRC][$];
  sb_t    sb_q[$];
  burst_t burst_log[$];
  int     checks = 0;
  int     failures = 0;
  int     seq = 0;
  int     xfer_total = 0;
  bit     sb_en = 1'b1;
  logic [NUM_SRC-1:0] hs_q = '0;
  int     cur_len = 0, cur_cyc = 0, cur_src = 0;
  logic   prev_busy = 1'b0;

  fifo_wr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_full (fifo_wr_full),
    .grant_id     (grant_id),
`ifdef FIFO_WR_ARB_STATS_EN
    .stat_sel     (stat_sel),
    .stat_cnt     (stat_cnt),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic drive_sources();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_q[i].size() > 0) begin
        src_valid[i]           = 1'b1;
        src_last[i]            = src_q[i][0].last;
        src_data[i*DW +: DW]   = src_q[i][0].data;
      end else begin
        src_valid[i]           = 1'b0;
        src_last[i]            = 1'b0;
        src_data[i*DW +: DW]   = '0;
      end
    end
  endtask

  // Source models retire the word accepted at this edge and present the next one.
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++)
      if (hs_q[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    hs_q = '0;
    drive_sources();
  end

  // Mid-cycle monitor: scoreboard compare of every FIFO write, plus burst shape log.
  always @(negedge clk) begin
    sb_t e;
    hs_q = src_valid & src_ready;
    if (fifo_wr_en) begin
      xfer_total++;
      checks++;
      if (fifo_wr_full) begin
        failures++;
        $display("[TB] FAIL wr_en_while_full: fifo_wr_en=1 with fifo_wr_full=1 at %0t", $time);
      end
      if (sb_en) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_write: got grant=%0d data=%h, expected no write", grant_id, fifo_wr_data);
        end else begin
          e = sb_q.pop_front();
          if (grant_id !== ID_W'(e.src) || fifo_wr_data !== e.data) begin
            failures++;
            $display("[TB] FAIL write_word: got grant=%0d data=%h, expected grant=%0d data=%h",
                     grant_id, fifo_wr_data, e.src, e.data);
          end
        end
      end
    end
    if (busy) begin
      if (!prev_busy) begin
        cur_len = 0;
        cur_cyc = 0;
      end
      cur_src = int'(grant_id);
      cur_cyc++;
      if (fifo_wr_en) cur_len++;
    end else if (prev_busy) begin
      burst_log.push_back('{cur_src, cur_len, cur_cyc});
    end
    prev_busy = busy;
  end

  task automatic push_word(input int s, input logic last);
    logic [DW-1:0] d;
    d = {8'(s), 16'(seq)};
    seq++;
    src_q[s].push_back('{d, last});
    if (sb_en) sb_q.push_back('{s, d});
  endtask

  task automatic wait_drain(input int budget);
    int  n = 0;
    bool_loop: while (n < budget) begin
      @(negedge clk);
      n++;
      if (!busy && src_q[0].size() == 0 && src_q[1].size() == 0 &&
          src_q[2].size() == 0 && src_q[3].size() == 0) break;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n >= budget) begin
      failures++;
      $display("[TB] FAIL drain_timeout: still busy after %0d cycles, expected idle", budget);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL words_missing: %0d expected writes never seen, expected 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    if (src_ready !== '0) begin failures++; $display("[TB] FAIL reset_ready: got %b, expected 0000", src_ready); end
    if (fifo_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en: got %b, expected 0", fifo_wr_en); end
    if (grant_id !== '0) begin failures++; $display("[TB] FAIL reset_grant: got %0d, expected 0", grant_id); end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset: busy=%b, expected 0", busy); end
  endtask

  task automatic test_round_robin();
    burst_t exp[$];
    @(negedge clk);
    push_word(0, 1'b1); push_word(1, 1'b1); push_word(2, 1'b1); push_word(3, 1'b1); push_word(0, 1'b1);
    for (int i = 0; i < 5; i++) exp.push_back('{i % 4, 1, 1});
    wait_drain(200);
    checks++;
    if (burst_log.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL rr_burst_count: got %0d, expected %0d", burst_log.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < burst_log.size(); k++) begin
      checks++;
      if (burst_log[k] != exp[k]) begin
        failures++;
        $display("[TB] FAIL rr_burst[%0d]: got src=%0d len=%0d cyc=%0d, expected src=%0d len=%0d cyc=%0d",
                 k, burst_log[k].src, burst_log[k].len, burst_log[k].cyc, exp[k].src, exp[k].len, exp[k].cyc);
      end
    end
    burst_log.delete();
  endtask

  task automatic test_burst_split();
    burst_t exp[$];
    @(negedge clk);
    for (int k = 0; k < 20; k++) push_word(2, 1'b0);
    wait_drain(300);
    @(negedge clk);
    push_word(3, 1'b1);
    push_word(0, 1'b1);
    wait_drain(100);
    exp.push_back('{2, 8, 8});
    exp.push_back('{2, 8, 8});
    exp.push_back('{2, 4, 5});
    exp.push_back('{3, 1, 1});
    exp.push_back('{0, 1, 1});
    checks++;
    if (burst_log.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL split_burst_count: got %0d, expected %0d", burst_log.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < burst_log.size(); k++) begin
      checks++;
      if (burst_log[k] != exp[k]) begin
        failures++;
        $display("[TB] FAIL split_burst[%0d]: got src=%0d len=%0d cyc=%0d, expected src=%0d len=%0d cyc=%0d",
                 k, burst_log[k].src, burst_log[k].len, burst_log[k].cyc, exp[k].src, exp[k].len, exp[k].cyc);
      end
    end
    burst_log.delete();
  endtask

  task automatic test_full_stall();
    burst_t exp[$];
    int     base, n;
    base = xfer_total;
    n = 0;
    @(negedge clk);
    for (int k = 0; k < 9; k++) push_word(1, 1'b0);
    while (xfer_total != base + 3 && n < 100) begin @(posedge clk); n++; end
    #2 fifo_wr_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b0 || src_ready[1] !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_cycle%0d: wr_en=%b ready1=%b busy=%b, expected 0 0 1",
                 c, fifo_wr_en, src_ready[1], busy);
      end
    end
    @(posedge clk);
    #2 fifo_wr_full = 1'b0;
    wait_drain(200);
    exp.push_back('{1, 8, 13});
    exp.push_back('{1, 1, 2});
    checks++;
    if (burst_log.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL stall_burst_count: got %0d, expected %0d", burst_log.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < burst_log.size(); k++) begin
      checks++;
      if (burst_log[k] != exp[k]) begin
        failures++;
        $display("[TB] FAIL stall_burst[%0d]: got src=%0d len=%0d cyc=%0d, expected src=%0d len=%0d cyc=%0d",
                 k, burst_log[k].src, burst_log[k].len, burst_log[k].cyc, exp[k].src, exp[k].len, exp[k].cyc);
      end
    end
    burst_log.delete();
  endtask

  task automatic test_reset_mid_burst();
    burst_t exp[$];
    int     base, n;
    base = xfer_total;
    n = 0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) push_word(0, 1'b0);
    while (xfer_total != base + 2 && n < 100) begin @(posedge clk); n++; end
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (busy !== 1'b0 || src_ready !== '0 || fifo_wr_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_same_cycle: busy=%b ready=%b wr_en=%b, expected 0 0000 0", busy, src_ready, fifo_wr_en);
    end
    if (sb_q.size() != 4) begin
      failures++;
      $display("[TB] FAIL words_before_reset: %0d words left unwritten, expected 4", sb_q.size());
    end
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    sb_q.delete();
    hs_q = '0;
    drive_sources();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    push_word(0, 1'b1);
    push_word(1, 1'b1);
    wait_drain(100);
    exp.push_back('{0, 2, 2});
    exp.push_back('{0, 1, 1});
    exp.push_back('{1, 1, 1});
    checks++;
    if (burst_log.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL rst_burst_count: got %0d, expected %0d", burst_log.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < burst_log.size(); k++) begin
      checks++;
      if (burst_log[k] != exp[k]) begin
        failures++;
        $display("[TB] FAIL rst_burst[%0d]: got src=%0d len=%0d cyc=%0d, expected src=%0d len=%0d cyc=%0d",
                 k, burst_log[k].src, burst_log[k].len, burst_log[k].cyc, exp[k].src, exp[k].len, exp[k].cyc);
      end
    end
    burst_log.delete();
  endtask

  task automatic test_valid_drop();
    burst_t exp[$];
    @(negedge clk);
    push_word(3, 1'b0);
    push_word(3, 1'b0);
    push_word(0, 1'b1);
    wait_drain(100);
    exp.push_back('{3, 2, 3});
    exp.push_back('{0, 1, 1});
    checks++;
    if (burst_log.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL drop_burst_count: got %0d, expected %0d", burst_log.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < burst_log.size(); k++) begin
      checks++;
      if (burst_log[k] != exp[k]) begin
        failures++;
        $display("[TB] FAIL drop_burst[%0d]: got src=%0d len=%0d cyc=%0d, expected src=%0d len=%0d cyc=%0d",
                 k, burst_log[k].src, burst_log[k].len, burst_log[k].cyc, exp[k].src, exp[k].len, exp[k].cyc);
      end
    end
    burst_log.delete();
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats();
    @(posedge clk);
    #2 rst = 1'b1;
    stat_sel = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) push_word(1, k == 4);
    wait_drain(100);
    burst_log.delete();
    @(posedge clk);
    #2 stat_sel = 2'd1;
    @(negedge clk);
    checks++;
    if (stat_cnt !== 16'd0) begin failures++; $display("[TB] FAIL stat_latency: got %0d, expected 0 (port 0)", stat_cnt); end
    @(negedge clk);
    checks++;
    if (stat_cnt !== 16'd5) begin failures++; $display("[TB] FAIL stat_five: got %0d, expected 5", stat_cnt); end
    sb_en = 1'b0;
    for (int k = 0; k < 65540; k++) push_word(1, 1'b0);
    wait_drain(80000);
    burst_log.delete();
    @(negedge clk);
    checks++;
    if (stat_cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL stat_saturate: got %0d, expected 65535", stat_cnt); end
    sb_en = 1'b1;
  endtask
`endif

  initial begin
    rst          = 1'b1;
    fifo_wr_full = 1'b0;
    src_valid    = '0;
    src_last     = '0;
    src_data     = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_sel     = '0;
`endif
    test_reset();
    test_round_robin();
    test_burst_split();
    test_full_stall();
    test_reset_mid_burst();
    test_valid_drop();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
